// File: rtl/score_update_ctrl_if.sv
// Front-panel command bus for the score update controller: debounced buttons
// and team select in, registered scores and commit/saturate/error strobes out.
interface score_update_ctrl_if #(
    parameter int W = 7
);
    logic         btn_p1;
    logic         btn_p2;
    logic         btn_p3;
    logic         btn_undo;
    logic         btn_clr;
    logic         team_sel;
    logic [W-1:0] score_home;
    logic [W-1:0] score_away;
    logic         upd_valid;
    logic         sat;
    logic         err;

    modport master (
        output btn_p1, btn_p2, btn_p3, btn_undo, btn_clr, team_sel,
        input  score_home, score_away, upd_valid, sat, err
    );

    modport slave (
        input  btn_p1, btn_p2, btn_p3, btn_undo, btn_clr, team_sel,
        output score_home, score_away, upd_valid, sat, err
    );
endinterface

// File: rtl/score_update_ctrl.sv
// Score update controller: synchronizes operator buttons, turns presses into
// saturating add / undo / clear operations on the home and away scores, and
// strobes every commit. One operation takes IDLE -> CALC -> COMMIT.
module score_update_ctrl #(
    parameter int W         = 7,
    parameter int MAX_SCORE = 99
) (
    input  logic             clk,
    input  logic             rst_n,
    score_update_ctrl_if.slave sif
);
    typedef enum logic [1:0] {S_IDLE, S_CALC, S_COMMIT} state_t;
    typedef enum logic [1:0] {OP_ADD, OP_UNDO, OP_CLR} op_t;

    localparam logic [W-1:0] MAX_V = W'(MAX_SCORE);

    // Upper clamp for adds: returns {sat, value}.
    function automatic logic [W:0] fn_sat_hi(input logic [W:0] t);
        if (t > {1'b0, MAX_V}) return {1'b1, MAX_V};
        else                   return {1'b0, t[W-1:0]};
    endfunction

    // Floor at zero for undo: a borrow out of the subtraction lands in bit W.
    function automatic logic [W:0] fn_sat_lo(input logic [W:0] t);
        if (t[W]) return '0 | {1'b1, {W{1'b0}}};
        else      return {1'b0, t[W-1:0]};
    endfunction

    logic [4:0]   w_btn;
    logic [4:0]   r_sync_p0, r_sync_p1, r_prev_p2;
    logic [4:0]   w_evt;
    logic         w_any;
    op_t          w_op;
    logic [1:0]   w_amt;
    state_t       r_state, w_next;
    logic         w_accept, w_drop, w_rej;
    op_t          r_op;
    logic [1:0]   r_amt;
    logic         r_team;
    logic [W:0]   r_temp;
    logic [W-1:0] r_home, r_away;
    logic         r_hist_vld, r_hist_team;
    logic [1:0]   r_hist_delta;
    logic         r_upd, r_sat, r_err, r_rej_pend;
    logic [W-1:0] w_cur;
    logic [W:0]   w_res;
    logic [1:0]   w_delta;

    assign w_btn = {sif.btn_clr, sif.btn_undo, sif.btn_p3, sif.btn_p2, sif.btn_p1};

    // Two-flop synchronizer followed by a rising-edge history register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sync_p0 <= '0;
            r_sync_p1 <= '0;
            r_prev_p2 <= '0;
        end else begin
            r_sync_p0 <= w_btn;
            r_sync_p1 <= r_sync_p0;
            r_prev_p2 <= r_sync_p1;
        end
    end

    assign w_evt = r_sync_p1 & ~r_prev_p2;
    assign w_any = |w_evt;

    // Priority resolve of same-cycle events: clr > undo > p3 > p2 > p1.
    always_comb begin
        w_op  = OP_ADD;
        w_amt = 2'd0;
        if      (w_evt[4]) w_op  = OP_CLR;
        else if (w_evt[3]) w_op  = OP_UNDO;
        else if (w_evt[2]) w_amt = 2'd3;
        else if (w_evt[1]) w_amt = 2'd2;
        else if (w_evt[0]) w_amt = 2'd1;
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // FSM next state: accept in IDLE, reject undo without history, drop when busy.
    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        w_drop   = 1'b0;
        w_rej    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_any) begin
                    if (w_op == OP_UNDO && !r_hist_vld) begin
                        w_rej = 1'b1;
                    end else begin
                        w_accept = 1'b1;
                        w_next   = S_CALC;
                    end
                end
            end
            S_CALC: begin
                w_drop = w_any;
                w_next = S_COMMIT;
            end
            S_COMMIT: begin
                w_drop = w_any;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    assign w_cur   = r_team ? r_away : r_home;
    assign w_res   = (r_op == OP_UNDO) ? fn_sat_lo(r_temp) : fn_sat_hi(r_temp);
    // Applied delta is 0..3, so modulo-4 arithmetic on the low bits is exact.
    assign w_delta = w_res[1:0] - w_cur[1:0];

    // Operation latch, unclamped result, score commit, history and strobes.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_op         <= OP_ADD;
            r_amt        <= '0;
            r_team       <= 1'b0;
            r_temp       <= '0;
            r_home       <= '0;
            r_away       <= '0;
            r_hist_vld   <= 1'b0;
            r_hist_team  <= 1'b0;
            r_hist_delta <= '0;
            r_upd        <= 1'b0;
            r_sat        <= 1'b0;
            r_err        <= 1'b0;
            r_rej_pend   <= 1'b0;
        end else begin
            r_upd      <= 1'b0;
            r_sat      <= 1'b0;
            r_rej_pend <= w_rej;
            r_err      <= w_drop | r_rej_pend;
            if (w_accept) begin
                r_op   <= w_op;
                r_amt  <= w_amt;
                r_team <= (w_op == OP_UNDO) ? r_hist_team : sif.team_sel;
            end
            if (r_state == S_CALC) begin
                if (r_op == OP_UNDO) r_temp <= {1'b0, w_cur} - {{(W-1){1'b0}}, r_hist_delta};
                else                 r_temp <= {1'b0, w_cur} + {{(W-1){1'b0}}, r_amt};
            end
            if (r_state == S_COMMIT) begin
                r_upd <= 1'b1;
                if (r_op == OP_CLR) begin
                    r_home     <= '0;
                    r_away     <= '0;
                    r_hist_vld <= 1'b0;
                end else begin
                    if (r_team) r_away <= w_res[W-1:0];
                    else        r_home <= w_res[W-1:0];
                    r_sat <= w_res[W];
                    if (r_op == OP_UNDO) begin
                        r_hist_vld <= 1'b0;
                    end else begin
                        r_hist_vld   <= 1'b1;
                        r_hist_team  <= r_team;
                        r_hist_delta <= w_delta;
                    end
                end
            end
        end
    end

    assign sif.score_home = r_home;
    assign sif.score_away = r_away;
    assign sif.upd_valid  = r_upd;
    assign sif.sat        = r_sat;
    assign sif.err        = r_err;
endmodule

// File: tb/tb_score_update_ctrl.sv
// Directed bench for score_update_ctrl: button presses with hand-computed scores.
module tb_score_update_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_tests = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   n_upd = 0;
    int   n_err = 0;
    int   last_upd_cyc = -1;
    int   last_sat = 0;
    int   b_upd, b_err, kc;

    score_update_ctrl_if #(.W(7)) sif ();

    score_update_ctrl #(.W(7), .MAX_SCORE(99)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .sif   (sif)
    );

    always #5 clk = ~clk;

    // Cycle counter advanced on every active edge.
    always @(posedge clk) cyc <= cyc + 1;

    // Strobe monitor sampled mid-cycle.
    always @(negedge clk) begin
        if (sif.upd_valid === 1'b1) begin
            n_upd = n_upd + 1;
            last_upd_cyc = cyc;
            last_sat = int'(sif.sat);
        end
        if (sif.err === 1'b1) n_err = n_err + 1;
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic set_btn(input logic [4:0] m);
        sif.btn_p1   = m[0];
        sif.btn_p2   = m[1];
        sif.btn_p3   = m[2];
        sif.btn_undo = m[3];
        sif.btn_clr  = m[4];
    endtask

    // One-edge press, then enough cycles for the op and synchronizer to drain.
    task automatic press(input logic [4:0] m);
        set_btn(m);
        step(1);
        set_btn(5'b0);
        step(7);
    endtask

    task automatic snap();
        b_upd = n_upd;
        b_err = n_err;
    endtask

    initial begin
        set_btn(5'b0);
        sif.team_sel = 1'b0;
        step(3);
        chk("rst_home", int'(sif.score_home), 0);
        chk("rst_away", int'(sif.score_away), 0);
        chk("rst_upd", int'(sif.upd_valid), 0);
        chk("rst_sat", int'(sif.sat), 0);
        chk("rst_err", int'(sif.err), 0);
        rst_n = 1'b1;
        step(2);

        // Held +2 on home: one commit, four edges after first sample.
        snap();
        sif.btn_p2 = 1'b1;
        step(1);
        kc = cyc;
        step(9);
        sif.btn_p2 = 1'b0;
        step(6);
        chk("hold_upd_cnt", n_upd - b_upd, 1);
        chk("hold_latency", last_upd_cyc, kc + 4);
        chk("hold_home", int'(sif.score_home), 2);
        chk("hold_away", int'(sif.score_away), 0);
        chk("hold_sat", last_sat, 0);
        chk("hold_err_cnt", n_err - b_err, 0);

        // Away to 97, then saturate, undo, and undo with no history.
        sif.team_sel = 1'b1;
        for (int i = 0; i < 32; i++) press(5'b00100);
        press(5'b00001);
        chk("away_97", int'(sif.score_away), 97);
        chk("home_kept", int'(sif.score_home), 2);
        press(5'b00100);
        chk("sat_away", int'(sif.score_away), 99);
        chk("sat_flag", last_sat, 1);
        press(5'b01000);
        chk("undo_away", int'(sif.score_away), 97);
        chk("undo_sat", last_sat, 0);
        snap();
        press(5'b01000);
        chk("undo2_err", n_err - b_err, 1);
        chk("undo2_upd", n_upd - b_upd, 0);
        chk("undo2_away", int'(sif.score_away), 97);

        // Simultaneous events resolved by priority.
        press(5'b10000);
        chk("clr_home", int'(sif.score_home), 0);
        chk("clr_away", int'(sif.score_away), 0);
        sif.team_sel = 1'b0;
        for (int i = 0; i < 3; i++) press(5'b00100);
        press(5'b00001);
        snap();
        press(5'b00101);
        chk("prio_home", int'(sif.score_home), 13);
        chk("prio_err", n_err - b_err, 0);
        chk("prio_upd", n_upd - b_upd, 1);
        press(5'b11000);
        chk("clrundo_home", int'(sif.score_home), 0);
        chk("clrundo_away", int'(sif.score_away), 0);
        snap();
        press(5'b01000);
        chk("hist_inval_err", n_err - b_err, 1);
        chk("hist_inval_upd", n_upd - b_upd, 0);

        // Second press lands while the first op is busy.
        snap();
        sif.btn_p1 = 1'b1;
        step(1);
        sif.btn_p1 = 1'b0;
        step(1);
        sif.btn_p2 = 1'b1;
        step(2);
        sif.btn_p2 = 1'b0;
        step(8);
        chk("busy_home", int'(sif.score_home), 1);
        chk("busy_err", n_err - b_err, 1);
        chk("busy_upd", n_upd - b_upd, 1);

        // Reset during CALC of +3 on home=50, button held through release.
        press(5'b10000);
        for (int i = 0; i < 16; i++) press(5'b00100);
        press(5'b00010);
        chk("home_50", int'(sif.score_home), 50);
        snap();
        sif.btn_p3 = 1'b1;
        step(3);
        rst_n = 1'b0;
        step(2);
        chk("mid_rst_home", int'(sif.score_home), 0);
        chk("mid_rst_away", int'(sif.score_away), 0);
        chk("mid_rst_upd", n_upd - b_upd, 0);
        rst_n = 1'b1;
        step(8);
        sif.btn_p3 = 1'b0;
        step(6);
        chk("rel_home", int'(sif.score_home), 3);
        chk("rel_upd", n_upd - b_upd, 1);

        // Undo follows history team, not the current team_sel.
        sif.team_sel = 1'b1;
        press(5'b00010);
        chk("away_2", int'(sif.score_away), 2);
        sif.team_sel = 1'b0;
        press(5'b01000);
        chk("undo_team_away", int'(sif.score_away), 0);
        chk("undo_team_home", int'(sif.score_home), 3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
